// File: rtl/apple_spawner_if.sv
// Snake-game apple bus: game side (master) drives step/spawn/snake, spawner (slave) returns apple state.
interface apple_spawner_if #(
  parameter int MAXLEN = 4
);
  logic                  step;
  logic                  spawn_req;
  logic [8*MAXLEN-1:0]   snake_x;
  logic [7*MAXLEN-1:0]   snake_y;
  logic [7:0]            apple_x;
  logic [6:0]            apple_y;
  logic                  apple_valid;
  logic                  eaten;
  logic                  busy;
  logic                  spawn_fail;

  modport master (
    output step, spawn_req, snake_x, snake_y,
    input  apple_x, apple_y, apple_valid, eaten, busy, spawn_fail
  );
  modport slave (
    input  step, spawn_req, snake_x, snake_y,
    output apple_x, apple_y, apple_valid, eaten, busy, spawn_fail
  );
endinterface

// File: rtl/apple_spawner.sv
// Apple owner for the snake game: eat detection plus LFSR-driven, overlap-rejecting respawn search.
// Optional APPLE_AUTO_RESPAWN_EN: an eat automatically launches a new search the following cycle.
module apple_spawner #(
  parameter int          XSCREEN   = 160,
  parameter int          YSCREEN   = 120,
  parameter int          XDIM      = 10,
  parameter int          YDIM      = 10,
  parameter int          MAXLEN    = 4,
  parameter logic [7:0]  APPLE_X0  = 8'd30,
  parameter logic [6:0]  APPLE_Y0  = 7'd30,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 64
) (
  input logic            CLOCK_50,
  input logic            Resetn,
  apple_spawner_if.slave bus
);
  localparam int COLS = XSCREEN / XDIM;
  localparam int ROWS = YSCREEN / YDIM;
  localparam int CB   = $clog2(COLS);
  localparam int RB   = $clog2(ROWS);
  localparam int IW   = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int TW   = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {IDLE, ROLL, CHECK, LOAD} state_t;

  state_t          r_state, w_state_n;
  logic [15:0]     r_lfsr;
  logic [7:0]      r_apple_x, r_cx;
  logic [6:0]      r_apple_y, r_cy;
  logic            r_valid, r_eaten, r_busy, r_fail;
  logic [IW-1:0]   r_idx;
  logic [TW-1:0]   r_tries;

  logic [CB-1:0]   w_col;
  logic [RB-1:0]   w_row;
  logic [7:0]      w_cand_x, w_seg_x, w_head_x;
  logic [6:0]      w_cand_y, w_seg_y, w_head_y;
  logic            w_in_range, w_seg_hit, w_eat, w_spawn, w_reject, w_give_up, w_last;

  assign w_col      = r_lfsr[CB-1:0];
  assign w_row      = r_lfsr[CB+RB-1:CB];
  assign w_in_range = (32'(w_col) < 32'(COLS)) && (32'(w_row) < 32'(ROWS));
  assign w_cand_x   = 8'(w_col) * 8'(XDIM);
  assign w_cand_y   = 7'(w_row) * 7'(YDIM);

  assign w_seg_x    = bus.snake_x[8*r_idx +: 8];
  assign w_seg_y    = bus.snake_y[7*r_idx +: 7];
  assign w_seg_hit  = (w_seg_x == r_cx) && (w_seg_y == r_cy);
  assign w_last     = (r_idx == IW'(MAXLEN - 1));

  assign w_head_x   = bus.snake_x[8*MAXLEN-1 -: 8];
  assign w_head_y   = bus.snake_y[7*MAXLEN-1 -: 7];
  assign w_eat      = (r_state == IDLE) && bus.step && r_valid &&
                      (w_head_x == r_apple_x) && (w_head_y == r_apple_y);

`ifdef APPLE_AUTO_RESPAWN_EN
  assign w_spawn    = bus.spawn_req | r_eaten;
`else
  assign w_spawn    = bus.spawn_req;
`endif

  assign w_reject   = ((r_state == ROLL) && !w_in_range) || ((r_state == CHECK) && w_seg_hit);
  assign w_give_up  = w_reject && (r_tries == TW'(MAX_TRIES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) r_state <= IDLE;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:  if (w_spawn) w_state_n = ROLL;
      ROLL:  if (w_in_range) w_state_n = CHECK;
      CHECK: if (w_seg_hit) w_state_n = ROLL;
             else if (w_last) w_state_n = LOAD;
      LOAD:  w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    if (w_give_up) w_state_n = IDLE;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_lfsr    <= SEED;
      r_apple_x <= APPLE_X0;
      r_apple_y <= APPLE_Y0;
      r_valid   <= 1'b1;
      r_eaten   <= 1'b0;
      r_busy    <= 1'b0;
      r_fail    <= 1'b0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_idx     <= '0;
      r_tries   <= '0;
    end else begin
      r_lfsr  <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      r_eaten <= w_eat;
      r_fail  <= w_give_up;
      if (w_eat) r_valid <= 1'b0;
      if (w_reject && !w_give_up) r_tries <= r_tries + 1'b1;
      case (r_state)
        IDLE: if (w_spawn) begin
          r_busy  <= 1'b1;
          r_valid <= 1'b0;
          r_tries <= '0;
        end
        ROLL: begin
          r_cx  <= w_cand_x;
          r_cy  <= w_cand_y;
          r_idx <= '0;
        end
        CHECK: if (!w_seg_hit) r_idx <= r_idx + 1'b1;
        LOAD: begin
          r_apple_x <= r_cx;
          r_apple_y <= r_cy;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
      // Exhausted search leaves the apple undrawn until the next request
      if (w_give_up) r_busy <= 1'b0;
    end
  end

  assign bus.apple_x     = r_apple_x;
  assign bus.apple_y     = r_apple_y;
  assign bus.apple_valid = r_valid;
  assign bus.eaten       = r_eaten;
  assign bus.busy        = r_busy;
  assign bus.spawn_fail  = r_fail;
endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner on a 2x2 grid: eat table, spawn search, exhaustion, reset abort.
module tb_apple_spawner;
`ifdef APPLE_AUTO_RESPAWN_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic Resetn   = 1'b0;
  int   errs     = 0;
  int   checks   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  apple_spawner_if #(.MAXLEN(4)) bus();

  apple_spawner #(
    .XSCREEN(20), .YSCREEN(20), .XDIM(10), .YDIM(10), .MAXLEN(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Resetn  (Resetn),
    .bus     (bus)
  );

  typedef struct {
    logic       step;
    logic [7:0] hx;
    logic [6:0] hy;
    logic       e_eaten;
    logic       e_valid;
    logic       e_busy;
  } vec_t;

  vec_t tv[6];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_snake(input logic [7:0] x3, x2, x1, x0, input logic [6:0] y3, y2, y1, y0);
    bus.snake_x = {x3, x2, x1, x0};
    bus.snake_y = {y3, y2, y1, y0};
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (bus.busy && n < 2000) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 2000), 1);
  endtask

  initial begin
    int n, fails;
    bus.step = 0; bus.spawn_req = 0;
    set_snake(8'd0, 8'd0, 8'd0, 8'd0, 7'd0, 7'd0, 7'd0, 7'd0);

    tv[0] = '{1'b1, 8'd40, 7'd30, 1'b0, 1'b1, 1'b0};
    tv[1] = '{1'b0, 8'd30, 7'd30, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 8'd30, 7'd40, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b1, 8'd30, 7'd30, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b0, 8'd30, 7'd30, 1'b0, 1'b0, AUTO};
    tv[5] = '{1'b1, 8'd30, 7'd30, 1'b0, 1'b0, AUTO};

    tick(); tick();
    chk("rst_ax", 32'(bus.apple_x), 30);
    chk("rst_ay", 32'(bus.apple_y), 30);
    chk("rst_valid", 32'(bus.apple_valid), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_eaten", 32'(bus.eaten), 0);
    chk("rst_fail", 32'(bus.spawn_fail), 0);
    Resetn = 1;

    for (int i = 0; i < 6; i++) begin
      bus.step = tv[i].step;
      set_snake(tv[i].hx, 8'd0, 8'd0, 8'd0, tv[i].hy, 7'd0, 7'd0, 7'd0);
      tick();
      chk($sformatf("v%0d_eaten", i), 32'(bus.eaten), 32'(tv[i].e_eaten));
      chk($sformatf("v%0d_valid", i), 32'(bus.apple_valid), 32'(tv[i].e_valid));
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tv[i].e_busy));
    end
    bus.step = 0;
    wait_idle("auto", n);

    // Only (10,10) is free: the search must land there
    set_snake(8'd0, 8'd10, 8'd0, 8'd0, 7'd10, 7'd0, 7'd0, 7'd10);
    bus.spawn_req = 1;
    tick();
    bus.spawn_req = 0;
    chk("sp_busy", 32'(bus.busy), 1);
    chk("sp_valid0", 32'(bus.apple_valid), 0);
    wait_idle("sp", n);
    chk("sp_busy_len", 32'(n >= 6), 1);
    chk("sp_ax", 32'(bus.apple_x), 10);
    chk("sp_ay", 32'(bus.apple_y), 10);
    chk("sp_valid", 32'(bus.apple_valid), 1);
    chk("sp_fail", 32'(bus.spawn_fail), 0);

    // Grid full, head on the apple: eat and spawn in the same cycle, then exhaustion
    set_snake(8'd10, 8'd0, 8'd10, 8'd0, 7'd10, 7'd0, 7'd0, 7'd10);
    bus.step = 1; bus.spawn_req = 1;
    tick();
    bus.step = 0; bus.spawn_req = 0;
    chk("full_eaten", 32'(bus.eaten), 1);
    chk("full_busy", 32'(bus.busy), 1);
    chk("full_valid", 32'(bus.apple_valid), 0);
    fails = 0; n = 0;
    while (bus.busy && n < 2000) begin
      tick();
      n++;
      if (bus.spawn_fail) fails++;
    end
    chk("full_timeout", 32'(n < 2000), 1);
    chk("full_fail_now", 32'(bus.spawn_fail), 1);
    tick();
    chk("full_fail_cnt", 32'(fails), 1);
    chk("full_fail_pulse", 32'(bus.spawn_fail), 0);
    chk("full_valid_end", 32'(bus.apple_valid), 0);
    chk("full_busy_end", 32'(bus.busy), 0);

    // Reset during a search restores the power-on apple
    set_snake(8'd0, 8'd10, 8'd0, 8'd0, 7'd10, 7'd0, 7'd0, 7'd10);
    bus.spawn_req = 1;
    tick();
    bus.spawn_req = 0;
    tick(); tick();
    chk("mid_busy", 32'(bus.busy), 1);
    Resetn = 0;
    tick();
    Resetn = 1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_ax", 32'(bus.apple_x), 30);
    chk("mid_rst_ay", 32'(bus.apple_y), 30);
    chk("mid_rst_valid", 32'(bus.apple_valid), 1);
    tick(); tick();
    chk("post_rst_busy", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
